// File: rtl/sel_feedback_mux.sv
// sel_feedback_mux
//   N-channel, WIDTH-bit selector with a registered select state and a
//   one-entry registered output stage using a valid/ready handshake.
//   The select state can hold, load, step round-robin, or step only when
//   the accepted word has odd parity (feedback mode).
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   ch_data    NCH packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid   selected channel's data is valid
//   in_ready   block accepts this cycle (combinational)
//   mode       00 HOLD, 01 LOAD, 10 ROUND_ROBIN, 11 FEEDBACK
//   sel_load   load request for sel_in (honoured in every mode)
//   sel_in     select value to load
//   sel_q      current select state
//   out_valid  out_data holds a word
//   out_ready  consumer takes out_data
//   out_data   registered selected word
//   sel_err    sticky: an out-of-range sel_in load was attempted
//   xfer_cnt   accepted-transfer count, wraps modulo 2^CNTW
module sel_feedback_mux #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned NCH   = 4,
  parameter  int unsigned CNTW  = 16,
  localparam int unsigned SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] ch_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic                 sel_load,
  input  logic [SELW-1:0]      sel_in,
  output logic [SELW-1:0]      sel_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 sel_err,
  output logic [CNTW-1:0]      xfer_cnt
);

  typedef enum logic [1:0] {
    M_HOLD = 2'b00,
    M_LOAD = 2'b01,
    M_RR   = 2'b10,
    M_FB   = 2'b11
  } mode_e;

  mode_e             mode_s;
  logic              accept;
  logic [WIDTH-1:0]  sel_word;
  logic              sel_ok;
  logic [SELW-1:0]   sel_inc;
  logic              advance;
  logic [SELW-1:0]   sel_nxt;

  assign mode_s   = mode_e'(mode);

  // A full register frees up in the same cycle it is drained.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // Compare-based mux so select codes >= NCH (non power-of-2 NCH) read as zero
  // rather than indexing past the packed bus.
  always_comb begin
    sel_word = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sel_q == SELW'(i)) begin
        sel_word = ch_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sel_ok  = (32'(sel_in) < NCH);
  assign sel_inc = (sel_q == SELW'(NCH - 1)) ? '0 : sel_q + SELW'(1);

  always_comb begin
    advance = 1'b0;
    case (mode_s)
      M_RR:    advance = accept;
      M_FB:    advance = accept & (^sel_word);
      default: advance = 1'b0;
    endcase
  end

  // Load wins over any advance; a rejected load still suppresses the advance.
  always_comb begin
    sel_nxt = sel_q;
    if (sel_load) begin
      if (sel_ok) begin
        sel_nxt = sel_in;
      end
    end else if (advance) begin
      sel_nxt = sel_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sel_err   <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      sel_q <= sel_nxt;
      if (sel_load && !sel_ok) begin
        sel_err <= 1'b1;
      end
      if (accept) begin
        out_data  <= sel_word;
        out_valid <= 1'b1;
        xfer_cnt  <= xfer_cnt + CNTW'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
